// File: rtl/prog_loader_pkg.sv
// Shared definitions for the tiny-processor program loader.
// Holds frame geometry, loader state encodings and the frame payload struct.
package prog_loader_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned IMEM_SZ = 1 << ADDR_W;
  localparam int unsigned GAP_CYC = 1;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TAIL,
    ST_GAP,
    ST_RUN
  } state_t;

  // Serial frame payload: address in the low bits, shifted out first
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } frame_t;

endpackage

// File: rtl/prog_loader_if.sv
// Host-side word/command port of the program loader.
//   in_valid/in_ready  word handshake
//   in_addr/in_data    imem address and instruction word
//   in_last            final word of a program
//   run_start/run_stop execution control pulses
// master: host driving words and commands; slave: the loader.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              run_start;
  logic              run_stop;

  modport master (
    output in_valid, in_addr, in_data, in_last, run_start, run_stop,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_last, run_start, run_stop,
    output in_ready
  );

endinterface

// File: rtl/prog_loader_frame_serializer.sv
// 12-bit load/shift register feeding the processor's serial load port.
//   clk, rst_n  clock, async active-low reset
//   load        capture frame_in
//   shift       shift right one bit (zero fill)
//   frame_in    frame to serialize
//   bit0        current serial bit (reg[0])
//   bit1        bit that becomes current after the next shift (reg[1])
module prog_loader_frame_serializer
  import prog_loader_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   shift,
  input  frame_t frame_in,
  output logic   bit0,
  output logic   bit1
);

  logic [FRAME_W-1:0] sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= frame_in;
    end else if (shift) begin
      sreg <= {1'b0, sreg[FRAME_W-1:1]};
    end
  end

  assign bit0 = sreg[0];
  assign bit1 = sreg[1];

endmodule

// File: rtl/prog_loader.sv
// Serial master for the tiny processor load port. Serializes (addr, data)
// words as 12-bit frames {data, addr} LSB first on csi_n/mosi, then starts
// and stops execution through en_proc.
//   clk, rst_n   clock, async active-low reset
//   bus          host word/command port (prog_loader_if.slave)
//   csi_n        instruction chip select, active low
//   mosi         serial data
//   en_proc      processor run enable
//   busy         high whenever not idle
//   frames_sent  saturating count of frames since reset or run_start
// Build option: PROG_LOADER_AUTORUN_EN -- a frame marked in_last moves the
// loader straight into RUN after its gap.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  prog_loader_if.slave     bus,
  output logic             csi_n,
  output logic             mosi,
  output logic             en_proc,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  state_t             state, state_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0]   frames_nxt;
  logic               ready_q;
  logic               load, shift, mosi_nxt, go_run;
  logic               ser_bit0, ser_bit1;
  frame_t             frame_in;

`ifdef PROG_LOADER_AUTORUN_EN
  logic last_q, last_nxt;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
`endif

  assign frame_in     = '{data: bus.in_data, addr: bus.in_addr};
  // run_start in IDLE takes priority over a word offered in the same cycle
  assign bus.in_ready = ready_q & ~bus.run_start;

  prog_loader_frame_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .frame_in (frame_in),
    .bit0     (ser_bit0),
    .bit1     (ser_bit1)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frames_sent <= '0;
      ready_q     <= 1'b0;
      csi_n       <= 1'b1;
      mosi        <= 1'b0;
      en_proc     <= 1'b0;
      busy        <= 1'b0;
`ifdef PROG_LOADER_AUTORUN_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      frames_sent <= frames_nxt;
      ready_q     <= (state_nxt == ST_IDLE);
      csi_n       <= (state_nxt != ST_LOAD);
      mosi        <= mosi_nxt;
      en_proc     <= (state_nxt == ST_RUN);
      busy        <= (state_nxt != ST_IDLE);
`ifdef PROG_LOADER_AUTORUN_EN
      last_q      <= last_nxt;
`endif
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    frames_nxt  = frames_sent;
    load        = 1'b0;
    shift       = 1'b0;
    mosi_nxt    = 1'b0;
`ifdef PROG_LOADER_AUTORUN_EN
    last_nxt    = last_q;
    go_run      = last_q;
`else
    go_run      = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (bus.run_start) begin
          state_nxt  = ST_RUN;
          frames_nxt = '0;
        end else if (bus.in_valid && ready_q) begin
          load        = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = ST_LOAD;
`ifdef PROG_LOADER_AUTORUN_EN
          last_nxt    = bus.in_last;
`endif
        end
      end
      ST_LOAD: begin
        // L0 holds the frame unshifted so L1 presents frame[0]; every later
        // cycle shifts, so the bit shown next cycle is reg[1]
        mosi_nxt = (bit_cnt == '0) ? ser_bit0 : ser_bit1;
        shift    = (bit_cnt != '0);
        if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
          state_nxt = ST_TAIL;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      ST_TAIL: begin
        state_nxt   = ST_GAP;
        gap_cnt_nxt = '0;
        if (frames_sent != '1) begin
          frames_nxt = frames_sent + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
          if (go_run) begin
            state_nxt  = ST_RUN;
            frames_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.run_stop) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a small model of the processor's
// serial receive port and instruction memory.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             csi_n, mosi, en_proc, busy;
  logic [CNT_W-1:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef PROG_LOADER_AUTORUN_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .csi_n       (csi_n),
    .mosi        (mosi),
    .en_proc     (en_proc),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  // Processor receive model: shifts while the previous cycle had csi_n low,
  // writes imem on the edge after the 12th shift
  logic [DATA_W-1:0]  imem [IMEM_SZ];
  logic [FRAME_W-1:0] rx_sr;
  logic               csi_d;
  int                 nsh;
  int                 wr_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csi_d <= 1'b1;
      nsh   <= 0;
      rx_sr <= '0;
    end else begin
      csi_d <= csi_n;
      if (!csi_d) begin
        rx_sr <= {mosi, rx_sr[FRAME_W-1:1]};
        nsh   <= nsh + 1;
      end else if (nsh == FRAME_W) begin
        imem[rx_sr[ADDR_W-1:0]] <= rx_sr[FRAME_W-1:ADDR_W];
        wr_cnt <= wr_cnt + 1;
        nsh    <= 0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word and hold it until accepted; returns at L0 (+1 after edge)
  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic last, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_last  = last;
    #1;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      else step(1);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    step(1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] wdat(input int i);
    return DATA_W'(i * 17 + 3);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [16];
    int a0;
    int wsnap;
    logic [FRAME_W-1:0] f;

    for (int i = 0; i < int'(IMEM_SZ); i++) imem[i] = '0;
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.run_start = 1'b0;
    bus.run_stop  = 1'b0;

    // Reset values
    #12;
    check("rst_csi_n", 32'(csi_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_en_proc", 32'(en_proc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    step(2);

    // 1: addr 3 data A5 -> frame A53
    f = 12'hA53;
    send(4'h3, 8'hA5, 1'b0, a0);
    check("t1_L0_csi", 32'(csi_n), 32'd0);
    check("t1_L0_mosi", 32'(mosi), 32'd0);
    for (int k = 0; k < 11; k++) begin
      step(1);
      check($sformatf("t1_L%0d_csi", k + 1), 32'(csi_n), 32'd0);
      check($sformatf("t1_L%0d_mosi", k + 1), 32'(mosi), 32'(f[k]));
    end
    step(1);
    check("t1_tail_csi", 32'(csi_n), 32'd1);
    check("t1_tail_mosi", 32'(mosi), 32'd1);
    step(1);
    check("t1_gap_frames", 32'(frames_sent), 32'd1);
    check("t1_gap_busy", 32'(busy), 32'd1);
    check("t1_gap_mosi", 32'(mosi), 32'd0);
    step(2);
    check("t1_imem3", 32'(imem[3]), 32'hA5);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 4: run_start / run_stop from IDLE
    bus.run_start = 1'b1;
    #1;
    check("t4_ready_start", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.run_start = 1'b0;
    check("t4_en_on", 32'(en_proc), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_frames_clr", 32'(frames_sent), 32'd0);
    check("t4_csi", 32'(csi_n), 32'd1);
    step(3);
    check("t4_ready_run", 32'(bus.in_ready), 32'd0);
    check("t4_en_hold", 32'(en_proc), 32'd1);
    bus.run_stop = 1'b1;
    @(posedge clk); #1;
    bus.run_stop = 1'b0;
    check("t4_en_off", 32'(en_proc), 32'd0);
    check("t4_busy_off", 32'(busy), 32'd0);
    check("t4_ready_back", 32'(bus.in_ready), 32'd1);

    // 2: 16 back-to-back words
    for (int i = 0; i < 16; i++) send(ADDR_W'(i), wdat(i), 1'b0, acc[i]);
    for (int i = 1; i < 16; i++) check($sformatf("t2_period%0d", i), 32'(acc[i] - acc[i-1]), 32'd15);
    step(16);
    check("t2_frames", 32'(frames_sent), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("t2_imem%0d", i), 32'(imem[i]), 32'(wdat(i)));

    // 3: reset mid-frame at L6, then a clean load
    send(4'h9, 8'h66, 1'b0, a0);
    step(6);
    check("t3_L6_csi", 32'(csi_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t3_rst_csi", 32'(csi_n), 32'd1);
    check("t3_rst_mosi", 32'(mosi), 32'd0);
    check("t3_rst_busy", 32'(busy), 32'd0);
    check("t3_rst_ready", 32'(bus.in_ready), 32'd0);
    check("t3_rst_frames", 32'(frames_sent), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(2);
    send(4'h5, 8'h3C, 1'b0, a0);
    step(16);
    check("t3_imem5", 32'(imem[5]), 32'h3C);
    check("t3_imem9_kept", 32'(imem[9]), 32'(wdat(9)));
    check("t3_frames", 32'(frames_sent), 32'd1);

    // 5: run_start and in_valid together
    wsnap = wr_cnt;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 4'h7;
    bus.in_data   = 8'hEE;
    bus.run_start = 1'b1;
    #1;
    check("t5_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.run_start = 1'b0;
    check("t5_en", 32'(en_proc), 32'd1);
    check("t5_csi", 32'(csi_n), 32'd1);
    check("t5_ready_run", 32'(bus.in_ready), 32'd0);
    step(3);
    check("t5_csi_hold", 32'(csi_n), 32'd1);
    bus.in_valid = 1'b0;
    bus.run_stop = 1'b1;
    @(posedge clk); #1;
    bus.run_stop = 1'b0;
    check("t5_en_off", 32'(en_proc), 32'd0);
    step(3);
    check("t5_no_write", 32'(wr_cnt - wsnap), 32'd0);
    check("t5_imem7", 32'(imem[7]), 32'(wdat(7)));

    // 6: three words, last flagged on the third
    send(4'hA, 8'h11, 1'b0, a0);
    send(4'hB, 8'h22, 1'b0, a0);
    send(4'hC, 8'h33, 1'b1, a0);
    step(13);
    check("t6_gap_en", 32'(en_proc), 32'd0);
    check("t6_gap_busy", 32'(busy), 32'd1);
    step(1);
    check("t6_en_after", 32'(en_proc), 32'(AR));
    check("t6_busy_after", 32'(busy), 32'(AR));
    check("t6_imemC", 32'(imem[12]), 32'h33);
    check("t6_imemA", 32'(imem[10]), 32'h11);
    bus.run_stop = 1'b1;
    @(posedge clk); #1;
    bus.run_stop = 1'b0;
    check("t6_en_final", 32'(en_proc), 32'd0);
    check("t6_busy_final", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
